// File: rtl/fft_frame_loader.sv
// Ping-pong frame buffer: packs i2s samples into 2^N_2-sample frames and streams them to the fft.
// Build option MONO_MIX_EN: capture (left+right)/2 instead of the left channel alone.
module fft_frame_loader #(
  parameter int unsigned width = 16,
  parameter int unsigned N_2   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lrck,
  input  logic [23:0]      left,
  input  logic [23:0]      right,
  input  logic             fft_done,
  output logic             fft_start,
  output logic             fft_load,
  output logic [width-1:0] fft_rd,
  output logic             overrun
);
  localparam int unsigned DEPTH = 1 << N_2;
  localparam logic [N_2-1:0] LAST_IDX = N_2'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, LOAD, WAIT} state_e;

  state_e           state_q, state_d;
  logic             lrck_q, done_q;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [N_2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [N_2-1:0]   rd_idx_q, rd_idx_d;
  logic             start_q, start_d;
  logic             load_q, load_d;
  logic             overrun_q, overrun_d;
  logic [width-1:0] rd_q, rd_d;
  logic             pair_c;
  logic [width-1:0] sample_c;
  logic [width-1:0] mem_q [DEPTH*2];

`ifdef MONO_MIX_EN
  logic signed [24:0] sum_c;
  logic               unused_c;
  assign sum_c    = 25'($signed(left)) + 25'($signed(right));
  assign sample_c = sum_c[24 -: width];
  assign unused_c = ^sum_c[24-width:0];
`else
  logic unused_c;
  assign sample_c = left[23 -: width];
  assign unused_c = ^{left[23-width:0], right};
`endif

  // A completed left/right pair is announced by the lrck 1->0 edge.
  assign pair_c = lrck_q & ~lrck;

  always_ff @(posedge clk) begin
    if (pair_c) mem_q[{wr_bank_q, wr_ptr_q}] <= sample_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lrck_q    <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_idx_q  <= '0;
      start_q   <= 1'b0;
      load_q    <= 1'b0;
      overrun_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      lrck_q    <= lrck;
      done_q    <= fft_done;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_idx_q  <= rd_idx_d;
      start_q   <= start_d;
      load_q    <= load_d;
      overrun_q <= overrun_d;
      rd_q      <= rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_idx_d  = rd_idx_q;
    start_d   = 1'b0;
    load_d    = 1'b0;
    overrun_d = overrun_q;
    rd_d      = '0;

    case (state_q)
      IDLE: begin
        if (full_q[~wr_bank_q]) begin
          state_d   = START;
          start_d   = 1'b1;
          rd_bank_d = ~wr_bank_q;
        end
      end
      START: begin
        state_d  = LOAD;
        load_d   = 1'b1;
        rd_idx_d = '0;
        rd_d     = mem_q[{rd_bank_q, {N_2{1'b0}}}];
      end
      LOAD: begin
        if (rd_idx_q == LAST_IDX) begin
          state_d           = WAIT;
          full_d[rd_bank_q] = 1'b0;
        end else begin
          rd_idx_d = rd_idx_q + N_2'(1);
          load_d   = 1'b1;
          rd_d     = mem_q[{rd_bank_q, rd_idx_d}];
        end
      end
      WAIT: begin
        if (done_q && !fft_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Uses full_d so a bank freed by the final LOAD cycle counts as free here.
    if (pair_c) begin
      wr_ptr_d = wr_ptr_q + N_2'(1);
      if (wr_ptr_q == LAST_IDX) begin
        wr_ptr_d = '0;
        if (!full_d[~wr_bank_q]) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  assign fft_start = start_q;
  assign fft_load  = load_q;
  assign fft_rd    = rd_q;
  assign overrun   = overrun_q;

endmodule
